// File: rtl/audio_i2s_transmitter.sv
// audio_i2s_transmitter: I2S serializer with one-entry sample holding register, BCLK/LRCK derived from MasterCLK
module audio_i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_HALF = 4
) (
  input  logic                    MasterCLK,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [SAMPLE_WIDTH-1:0] SampleL,
  input  logic [SAMPLE_WIDTH-1:0] SampleR,
  input  logic                    SampleValid,
  output logic                    SampleReady,
  output logic                    I2S_BCLK,
  output logic                    I2S_LRCK,
  output logic                    I2S_SDATA,
  output logic                    Underrun
);
  localparam int W = SAMPLE_WIDTH;
  localparam int DW = $clog2(BCLK_HALF);
  localparam int SW = $clog2(2 * W);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(2 * W - 1);
  localparam logic [SW-1:0] LR_LO = SW'(W - 1);
  localparam logic [SW-1:0] LR_HI = SW'(2 * W - 2);
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [2*W-1:0] shift_q, shift_d, hold_q, hold_d;
  logic bclk_q, bclk_d, lrck_q, lrck_d, full_q, full_d, urun_q, urun_d;
  logic wrap, fall, load, xfer;
  always_comb begin
    wrap = Enable && div_q == DIV_LAST;
    fall = wrap && bclk_q;
    load = fall && slot_q == SLOT_LAST;
    xfer = SampleValid && !full_q;
    div_d = (!Enable || wrap) ? '0 : div_q + DW'(1);
    bclk_d = Enable && (bclk_q ^ wrap);
    slot_d = !Enable ? SLOT_LAST : !fall ? slot_q : load ? '0 : slot_q + SW'(1);
    // LRCK leads the MSB by one BCLK, so it switches one slot before each channel
    lrck_d = Enable && (fall ? (slot_d >= LR_LO && slot_d <= LR_HI) : lrck_q);
    shift_d = !Enable ? '0 : load ? (full_q ? hold_q : '0) : fall ? shift_q << 1 : shift_q;
    full_d = xfer || (full_q && !load);
    hold_d = xfer ? {SampleL, SampleR} : hold_q;
    urun_d = load && !full_q;
  end
  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      div_q <= '0;
      slot_q <= SLOT_LAST;
      shift_q <= '0;
      hold_q <= '0;
      bclk_q <= 1'b0;
      lrck_q <= 1'b0;
      full_q <= 1'b0;
      urun_q <= 1'b0;
    end else begin
      div_q <= div_d;
      slot_q <= slot_d;
      shift_q <= shift_d;
      hold_q <= hold_d;
      bclk_q <= bclk_d;
      lrck_q <= lrck_d;
      full_q <= full_d;
      urun_q <= urun_d;
    end
  end
  assign SampleReady = !full_q;
  assign I2S_BCLK = bclk_q;
  assign I2S_LRCK = lrck_q;
  assign I2S_SDATA = shift_q[2*W-1];
  assign Underrun = urun_q;
endmodule
